// File: rtl/uart_rx_top.sv
// uart_rx_top: 16550-style UART receiver front end.
// Deserialises rx using a 16x oversampling enable, then checks parity,
// framing and break, and strobes each finished character toward the RX FIFO.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   baud_pulse          one-clk enable at 16x the bit rate
//   rx                  serial input (idles high)
//   sticky_parity, eps, pen, wls   LCR frame format, sampled live
//   push                one-clk FIFO write strobe per received character
//   pe, fe, bi          parity / framing / break flags of the last character
//   rx_out              received data, right-justified, upper bits zero
module uart_rx_top (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic       sticky_parity,
  input  logic       eps,
  input  logic       pen,
  input  logic [1:0] wls,
  output logic       push,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic [7:0] rx_out
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic                brk_q, brk_d;
  logic                perr_q, perr_d;
  logic                armed_q, armed_d;
  logic                push_d, pe_d, fe_d, bi_d;
  logic [DATA_W-1:0]   rx_out_d;

  logic                mid_c;
  logic                end_c;
  logic                last_bit_c;
  logic [1:0]          shift_c;
  logic                exp_par_c;

  // Tick and bit-count decodes; data lands MSB-first in sr, so right-justify
  // by shifting out the (8 - word length) unused low positions.
  assign mid_c      = (cnt_q == CNT_W'(7));
  assign end_c      = (cnt_q == CNT_W'(15));
  assign last_bit_c = (bit_q == (BIT_W'(wls) + BIT_W'(4)));
  assign shift_c    = 2'd3 - wls;
  // Unused sr positions are cleared at frame start, so ^sr is the data parity.
  assign exp_par_c  = sticky_parity ? ~eps : (eps ? (^sr_q) : ~(^sr_q));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      brk_q   <= 1'b0;
      perr_q  <= 1'b0;
      armed_q <= 1'b1;
      push    <= 1'b0;
      pe      <= 1'b0;
      fe      <= 1'b0;
      bi      <= 1'b0;
      rx_out  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      brk_q   <= brk_d;
      perr_q  <= perr_d;
      armed_q <= armed_d;
      push    <= push_d;
      pe      <= pe_d;
      fe      <= fe_d;
      bi      <= bi_d;
      rx_out  <= rx_out_d;
    end
  end

  // Next-state and output logic; nothing moves without baud_pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    brk_d    = brk_q;
    perr_d   = perr_q;
    armed_d  = armed_q;
    push_d   = 1'b0;
    pe_d     = pe;
    fe_d     = fe;
    bi_d     = bi;
    rx_out_d = rx_out;

    if (baud_pulse) begin
      // A line held low after a break must go high before a new start counts.
      if (rx) armed_d = 1'b1;

      unique case (state_q)
        IDLE: begin
          if (!rx && armed_q) begin
            state_d = START;
            cnt_d   = '0;
          end
        end

        START: begin
          if (mid_c) begin
            cnt_d = '0;
            if (!rx) begin
              state_d = DATA;
              bit_d   = '0;
              sr_d    = '0;
              brk_d   = 1'b1;
              perr_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (end_c) begin
            sr_d  = {rx, sr_q[DATA_W-1:1]};
            brk_d = brk_q & ~rx;
            if (last_bit_c) begin
              state_d = pen ? PARITY : STOP;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end

        PARITY: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (end_c) begin
            perr_d  = (rx != exp_par_c);
            brk_d   = brk_q & ~rx;
            state_d = STOP;
          end
        end

        STOP: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (end_c) begin
            push_d   = 1'b1;
            rx_out_d = sr_q >> shift_c;
            pe_d     = perr_q;
            fe_d     = ~rx;
            bi_d     = brk_q & ~rx;
            if (brk_q && !rx) armed_d = 1'b0;
            state_d  = IDLE;
            cnt_d    = '0;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: directed frames against a frame-level model of the receiver.
module tb_uart_rx_top;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_pulse = 1'b0;
  logic       rx = 1'b1;
  logic       sticky_parity = 1'b0;
  logic       eps = 1'b0;
  logic       pen = 1'b0;
  logic [1:0] wls = 2'b11;
  logic       push, pe, fe, bi;
  logic [7:0] rx_out;

  uart_rx_top dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx(rx),
    .sticky_parity(sticky_parity), .eps(eps), .pen(pen), .wls(wls),
    .push(push), .pe(pe), .fe(fe), .bi(bi), .rx_out(rx_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model of the held outputs: the last expected character.
  logic [7:0] m_out = 8'h00;
  logic       m_pe = 1'b0, m_fe = 1'b0, m_bi = 1'b0;
  logic       prev_push = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      m_out = 8'h00; m_pe = 1'b0; m_fe = 1'b0; m_bi = 1'b0;
      chk("reset_outputs", {20'd0, push, pe, fe, bi, rx_out}, 32'd0);
    end else begin
      if (push) begin
        if (prev_push) chk("push_width", 32'd2, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_push", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          m_out = e.d; m_pe = e.pe; m_fe = e.fe; m_bi = e.bi;
        end
      end
      chk("outputs", {21'd0, pe, fe, bi, rx_out}, {21'd0, m_pe, m_fe, m_bi, m_out});
    end
    prev_push = push;
  end

  // One baud tick: baud_pulse high for one clk, then three idle clks.
  task automatic tick();
    baud_pulse = 1'b1;
    @(posedge clk); #1;
    baud_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one frame; the last bit is held 9 ticks so the line is released
  // just after the stop sample. abort_at >= 0 stops after that many ticks.
  task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                            input bit par_bit, input bit stop_bit, input int tail_low,
                            input int abort_at);
    logic bits[$];
    int   total;
    int   ones;
    bit   want_par;
    exp_t e;
    wls = 2'(nbits - 5);
    pen = has_par;
    ones = 0;
    for (int i = 0; i < nbits; i++) ones += int'(data[i]);
    want_par = sticky_parity ? !eps : (eps ? bit'(ones % 2) : bit'(1 - ones % 2));
    e.d  = data & 8'((1 << nbits) - 1);
    e.pe = has_par && (par_bit != want_par);
    e.fe = !stop_bit;
    e.bi = (e.d == 8'h00) && (!has_par || !par_bit) && !stop_bit;
    if (abort_at < 0) exp_q.push_back(e);
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
    if (has_par) bits.push_back(par_bit);
    bits.push_back(stop_bit);
    total = 0;
    for (int k = 0; k < bits.size(); k++) begin
      for (int t = 0; t < ((k == bits.size() - 1) ? 9 : 16); t++) begin
        if (abort_at >= 0 && total == abort_at) return;
        rx = bits[k];
        tick();
        total++;
      end
    end
    rx = 1'b0;
    for (int i = 0; i < tail_low; i++) tick();
    idle_ticks(20);
    chk("frame_consumed", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_out(input string name, input logic [7:0] d, input logic epe,
                         input logic efe, input logic ebi);
    chk({name, "_data"}, 32'(rx_out), 32'(d));
    chk({name, "_flags"}, {29'd0, pe, fe, bi}, {29'd0, epe, efe, ebi});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle_ticks(4);

    // 8O1 (eps=0): 0x45 has three ones, so the correct parity bit is 0.
    eps = 1'b0; sticky_parity = 1'b0;
    send_frame(8'h45, 8, 1, 1'b0, 1'b1, 0, -1);
    chk_out("odd_ok", 8'h45, 1'b0, 1'b0, 1'b0);
    send_frame(8'h45, 8, 1, 1'b1, 1'b1, 0, -1);
    chk_out("odd_bad", 8'h45, 1'b1, 1'b0, 1'b0);
    send_frame(8'h45, 8, 1, 1'b0, 1'b0, 0, -1);
    chk_out("framing", 8'h45, 1'b0, 1'b1, 1'b0);

    // Break: line low through the whole 8E1 frame and beyond; no second push.
    eps = 1'b1;
    send_frame(8'h00, 8, 1, 1'b0, 1'b0, 40, -1);
    chk_out("break", 8'h00, 1'b0, 1'b1, 1'b1);

    // 5N1 then 5-bit stick parity (expected bit ~eps = 0, sent 1).
    eps = 1'b0;
    send_frame(8'h15, 5, 0, 1'b0, 1'b1, 0, -1);
    chk_out("w5_none", 8'h15, 1'b0, 1'b0, 1'b0);
    sticky_parity = 1'b1; eps = 1'b1;
    send_frame(8'h15, 5, 1, 1'b1, 1'b1, 0, -1);
    chk_out("w5_stick", 8'h15, 1'b1, 1'b0, 1'b0);
    sticky_parity = 1'b0;

    // 7E1 0x5A (four ones, even parity bit 0) and 6O1 0x2B (four ones, bit 1).
    eps = 1'b1;
    send_frame(8'h5A, 7, 1, 1'b0, 1'b1, 0, -1);
    chk_out("w7_even", 8'h5A, 1'b0, 1'b0, 1'b0);
    eps = 1'b0;
    send_frame(8'h2B, 6, 1, 1'b1, 1'b1, 0, -1);
    chk_out("w6_odd", 8'h2B, 1'b0, 1'b0, 1'b0);
    // Upper bits of the sent byte beyond the word length are dropped.
    send_frame(8'hF3, 6, 0, 1'b0, 1'b1, 0, -1);
    chk_out("w6_mask", 8'h33, 1'b0, 1'b0, 1'b0);

    // Start glitch: low for 5 ticks only.
    rx = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    idle_ticks(30);
    chk("glitch_no_push", 32'(exp_q.size()), 32'd0);
    chk_out("glitch_hold", 8'h33, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA7, 8, 0, 1'b0, 1'b1, 0, -1);
    chk_out("after_glitch", 8'hA7, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a valid character.
    send_frame(8'h81, 8, 0, 1'b0, 1'b1, 0, 70);
    rst = 1'b0;
    #2;
    chk_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mid_reset_push", 32'(push), 32'd0);
    exp_q.delete();
    rx = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    idle_ticks(200);
    chk_out("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 0, 1'b0, 1'b1, 0, -1);
    chk_out("post_reset_frame", 8'h3C, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_top.md
# uart_rx_top

16550-style UART receiver front end. Deserialises an asynchronous serial line using a 16x oversampling enable (`baud_pulse`) supplied by the baud generator, and checks parity, framing and break. Each completed character is pushed into the receive FIFO with its error flags. Frame format (word length, parity enable, even/stick parity) comes straight from the LCR fields.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset; clears all state.
- `baud_pulse`  in  1  one-`clk`-wide enable at 16x the bit rate; all sampling and counting happens only on cycles where it is 1.
- `rx`  in  1  serial input; idles high.
- `sticky_parity`  in  1  LCR stick-parity bit.
- `eps`  in  1  LCR even-parity select: 1 = even, 0 = odd.
- `pen`  in  1  LCR parity enable.
- `wls`  in  2  word length: 00 = 5, 01 = 6, 10 = 7, 11 = 8 data bits.
- `push`  out  1  one-`clk` pulse when a character is complete (FIFO write strobe).
- `pe`  out  1  parity error of the last character.
- `fe`  out  1  framing error of the last character (stop bit sampled 0).
- `bi`  out  1  break indication of the last character.
- `rx_out`  out  8  received data, right-justified; unused upper bits are 0. This is the last port, after `bi`.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- A 4-bit tick counter advances on `baud_pulse`.
- A bit counter counts data bits.
- A shift register takes data LSB-first.
- A break tracker holds 1 while every sampled bit of the frame is 0.
- IDLE:
  - On a `baud_pulse` with `rx`=0, go to START with counter=0.
- START:
  - At counter 7 (mid start bit), if `rx`=0, go to DATA with counter=0 and bit count=0.
  - If `rx`=1 at that point, it was a glitch: return to IDLE with no push.
- DATA:
  - At counter 15, sample `rx` into the shift register.
  - After `wls`+5 bits, go to PARITY if `pen`=1, else STOP.
- PARITY: at counter 15, sample the parity bit.
  - Expected bit:
    - `sticky_parity`=1: expected = ~`eps`.
    - Otherwise, `eps`=1: XOR of the data bits.
    - Otherwise, `eps`=0: XNOR of the data bits.
  - Set `pe_next` = received != expected.
- STOP: at counter 15, sample the stop bit.
  - `fe_next` = ~`rx`.
  - `bi_next` = 1 if data, parity (when enabled) and stop all sampled 0.
  - Then assert `push`, load `rx_out`/`pe`/`fe`/`bi`, and return to IDLE.
- With `pen`=0, `pe` is 0.
- `wls`, `pen`, `eps` and `sticky_parity` must be stable during a frame; they are sampled live.
- After a break frame, the receiver re-enters IDLE.
  - A new start is detected only after `rx` is seen high, then low again.

## Timing
- Reset values: `push`=0, `pe`=0, `fe`=0, `bi`=0, `rx_out`=0x00. FSM in IDLE, counters 0.
- Sampling points:
  - Start bit: mid-bit, 8 `baud_pulse`s after the falling edge is detected.
  - Each later bit: every 16 `baud_pulse`s after that, i.e. mid-bit.
- `push`:
  - Goes high in the `clk` cycle after the `baud_pulse` that samples the stop bit.
  - Lasts exactly one `clk`.
- Registered outputs:
  - `rx_out`, `pe`, `fe` and `bi` change in the same cycle `push` goes high.
  - They hold until the next push.
- Exactly one `push` per received frame. No push for a rejected start glitch.
- Asserting `rst` mid-frame: immediate return to the reset values, and no push for the partial frame.
- Cycles with `baud_pulse`=0 never change FSM state or counters.

## Test plan
- `wls`=11, `pen`=1, `eps`=0, `sticky`=0. Send start, 0x45 LSB-first, parity 0, stop 1, each bit 16 ticks.
  - Expect: one `push`, `rx_out`=0x45, `pe`=0, `fe`=0, `bi`=0.
- Same frame with parity bit 1.
  - Expect: `push`, `rx_out`=0x45, `pe`=1, `fe`=0.
- Same frame with stop bit 0.
  - Expect: `push`, `fe`=1, `pe`=0, `bi`=0.
- `rx` held 0 for the whole 8E1 frame (`eps`=1).
  - Expect: `push`, `rx_out`=0x00, `bi`=1, `fe`=1.
- `wls`=00, `pen`=0. Send 0x15 with stop 1.
  - Expect: `rx_out`=0x15, `pe`=0.
  - Then `sticky`=1, `eps`=1, `pen`=1, parity bit 1. Expect `pe`=1.
- Start glitch: `rx` low for 5 ticks.
  - Expect: no `push`, and the FSM returns to IDLE.
  - Then assert `rst` mid-frame of a valid character. Expect all outputs 0 and no `push`.
